// File: rtl/hamming_decoder_72.sv
// 72/64 SECDED decoder: a four-state pipeline (accept, syndrome, correct, present)
// with a valid/ready handshake on both sides and saturating error counters.
module hamming_decoder_72 (
   input  logic        clk,
   input  logic        rst,
   input  logic [71:0] code_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [63:0] data_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err_single,
   output logic        err_double,
   output logic [6:0]  syndrome_out,
   output logic [15:0] corr_cnt,
   output logic [15:0] dbl_cnt
);

   localparam int unsigned CodeW = 72;
   localparam int unsigned DataW = 64;
   localparam int unsigned SynW  = 7;
   localparam int unsigned CntW  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      OUT  = 2'd3
   } stateE;

   stateE              state;
   stateE              nextState;

   logic [CodeW-1:0]   codeReg;
   logic [SynW-1:0]    synReg;
   logic               parReg;

   logic [SynW-1:0]    synCalc;
   logic               parCalc;
   logic               flipBit;
   logic               isSingle;
   logic               isDouble;
   logic [DataW-1:0]   dataFixed;
   logic               loadCode;
   logic               loadSyn;
   logic               loadOut;
   logic               incCorr;
   logic               incDbl;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (in_valid)  nextState = CALC;
         CALC:                   nextState = FIX;
         FIX:                    nextState = OUT;
         OUT:     if (out_ready) nextState = IDLE;
         default:                nextState = IDLE;
      endcase
   end

   // Syndrome, classification, in-place correction and data extraction
   always_comb begin
      int d;
      synCalc   = '0;
      parCalc   = ^codeReg;
      isSingle  = 1'b0;
      isDouble  = 1'b0;
      flipBit   = 1'b0;
      dataFixed = '0;
      d         = 0;

      for (int p = 1; p < int'(CodeW); p++) begin
         if (codeReg[p]) synCalc = synCalc ^ SynW'(p);
      end

      if (parReg) begin
         if (synReg == '0) begin
            isSingle = 1'b1;
         end else if (synReg < SynW'(CodeW)) begin
            isSingle = 1'b1;
            flipBit  = 1'b1;
         end else begin
            isDouble = 1'b1;
         end
      end else if (synReg != '0) begin
         isDouble = 1'b1;
      end

      // Data occupies every non-power-of-two position, flipped where the syndrome points
      for (int p = 1; p < int'(CodeW); p++) begin
         if ((p & (p - 1)) != 0) begin
            dataFixed[d] = codeReg[p] ^ (flipBit && (synReg == SynW'(p)));
            d++;
         end
      end

      loadCode = (state == IDLE) && in_valid;
      loadSyn  = (state == CALC);
      loadOut  = (state == FIX);
      incCorr  = loadOut && isSingle && (corr_cnt != {CntW{1'b1}});
      incDbl   = loadOut && isDouble && (dbl_cnt  != {CntW{1'b1}});
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         codeReg      <= '0;
         synReg       <= '0;
         parReg       <= 1'b0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         data_out     <= '0;
         err_single   <= 1'b0;
         err_double   <= 1'b0;
         syndrome_out <= '0;
         corr_cnt     <= '0;
         dbl_cnt      <= '0;
      end else begin
         in_ready  <= (nextState == IDLE);
         out_valid <= (nextState == OUT);
         if (loadCode) codeReg <= code_in;
         if (loadSyn) begin
            synReg <= synCalc;
            parReg <= parCalc;
         end
         if (loadOut) begin
            data_out     <= dataFixed;
            err_single   <= isSingle;
            err_double   <= isDouble;
            syndrome_out <= synReg;
         end
         if (incCorr) corr_cnt <= corr_cnt + CntW'(1);
         if (incDbl)  dbl_cnt  <= dbl_cnt + CntW'(1);
      end
   end

endmodule
